// File: rtl/i2c_bus_decoder.sv
// I2C slave-side bus decoder: synchronises SCL/SDA, decodes START/STOP/edges, shifts in
// bytes and matches the address byte against NUM_ADDR entries. Optional: I2C_GLITCH_FILTER_EN.
module i2c_bus_decoder #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_ADDR    = 2,
   parameter int IDX_W       = 1,
   parameter int FILTER_LEN  = 3
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  scl,
   input  logic                  sda_in,
   input  logic [NUM_ADDR*7-1:0] slave_addrs,
   input  logic [NUM_ADDR-1:0]   addr_en,
   output logic                  start_found,
   output logic                  stop_found,
   output logic                  scl_rise,
   output logic                  scl_fall,
   output logic                  address_match,
   output logic [IDX_W-1:0]      match_idx,
   output logic                  rw_mode,
   output logic [7:0]            rx_byte,
   output logic                  byte_valid,
   output logic                  ack_slot
);

   typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, IGNORE} state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_cur, sda_cur, scl_prev, sda_prev;
   logic                   rise_c, fall_c, start_c, stop_c;
   state_t                 state_q, state_d;
   logic [3:0]             bit_cnt;
   logic [7:0]             shift_q;
   logic [7:0]             byte_in;
   logic                   hit_any;
   logic [IDX_W-1:0]       hit_idx;
   logic                   receiving;

   // Idle bus is high, so the chains reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge values.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   localparam int CNT_W = $clog2(FILTER_LEN + 1);
   logic [CNT_W-1:0] scl_cnt, sda_cnt;

   // A line's filtered value follows only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_cur <= 1'b1;
         sda_cur <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
      end else begin
         if (scl_sync[SYNC_STAGES-1] == scl_cur) begin
            scl_cnt <= '0;
         end else if (scl_cnt == CNT_W'(FILTER_LEN - 1)) begin
            scl_cur <= scl_sync[SYNC_STAGES-1];
            scl_cnt <= '0;
         end else begin
            scl_cnt <= scl_cnt + 1'b1;
         end
         if (sda_sync[SYNC_STAGES-1] == sda_cur) begin
            sda_cnt <= '0;
         end else if (sda_cnt == CNT_W'(FILTER_LEN - 1)) begin
            sda_cur <= sda_sync[SYNC_STAGES-1];
            sda_cnt <= '0;
         end else begin
            sda_cnt <= sda_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_filter_len;
   assign unused_filter_len = ^FILTER_LEN;
   assign scl_cur = scl_sync[SYNC_STAGES-1];
   assign sda_cur = sda_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_cur;
         sda_prev <= sda_cur;
      end
   end

   assign rise_c  = !scl_prev && scl_cur;
   assign fall_c  = scl_prev && !scl_cur;
   assign start_c = scl_prev && scl_cur && sda_prev && !sda_cur;
   assign stop_c  = scl_prev && scl_cur && !sda_prev && sda_cur;

   assign byte_in   = {shift_q[6:0], sda_cur};
   assign receiving = (state_q == ADDR) || (state_q == ACTIVE);

   // Iterating downwards leaves the lowest matching entry in hit_idx.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ADDR - 1; i >= 0; i--) begin
         if (addr_en[i] && (slave_addrs[7*i +: 7] == byte_in[7:1])) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_c) begin
         state_d = ADDR;
      end else if (stop_c) begin
         state_d = IDLE;
      end else if (state_q == ADDR && rise_c && bit_cnt == 4'd7) begin
         state_d = hit_any ? ACTIVE : IGNORE;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         start_found   <= 1'b0;
         stop_found    <= 1'b0;
         scl_rise      <= 1'b0;
         scl_fall      <= 1'b0;
         address_match <= 1'b0;
         match_idx     <= '0;
         rw_mode       <= 1'b0;
         rx_byte       <= '0;
         byte_valid    <= 1'b0;
         ack_slot      <= 1'b0;
         bit_cnt       <= '0;
         shift_q       <= '0;
      end else begin
         start_found <= start_c;
         stop_found  <= stop_c;
         scl_rise    <= rise_c;
         scl_fall    <= fall_c;
         byte_valid  <= 1'b0;
         if (start_c || stop_c) begin
            // Any bus condition discards a partial byte and the previous address result.
            address_match <= 1'b0;
            match_idx     <= '0;
            rw_mode       <= 1'b0;
            ack_slot      <= 1'b0;
            bit_cnt       <= '0;
            shift_q       <= '0;
         end else if (receiving) begin
            if (rise_c) begin
               bit_cnt <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
               if (bit_cnt != 4'd8) shift_q <= byte_in;
               if (bit_cnt == 4'd7) begin
                  rx_byte    <= byte_in;
                  byte_valid <= 1'b1;
                  if (state_q == ADDR) begin
                     address_match <= hit_any;
                     match_idx     <= hit_any ? hit_idx : '0;
                     rw_mode       <= byte_in[0];
                  end
               end
            end
            // The ACK window spans the 9th SCL period, fall to fall.
            if (fall_c && state_q == ACTIVE) begin
               if (bit_cnt == 4'd8)      ack_slot <= 1'b1;
               else if (bit_cnt == 4'd0) ack_slot <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_bus_decoder.sv
// Self-checking bench for i2c_bus_decoder: table of address-phase vectors plus
// hand-written sequences for data bytes, IGNORE, repeated START, aborts and reset.
module tb_i2c_bus_decoder;

   localparam int H = 8;  // clk cycles per quarter SCL period

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        scl = 1'b1;
   logic        sda_in = 1'b1;
   logic [13:0] slave_addrs = '0;
   logic [1:0]  addr_en = '0;
   logic        start_found, stop_found, scl_rise, scl_fall;
   logic        address_match, rw_mode, byte_valid, ack_slot;
   logic [0:0]  match_idx;
   logic [7:0]  rx_byte;

   i2c_bus_decoder dut (
      .clk(clk), .n_rst(n_rst), .scl(scl), .sda_in(sda_in),
      .slave_addrs(slave_addrs), .addr_en(addr_en),
      .start_found(start_found), .stop_found(stop_found),
      .scl_rise(scl_rise), .scl_fall(scl_fall),
      .address_match(address_match), .match_idx(match_idx), .rw_mode(rw_mode),
      .rx_byte(rx_byte), .byte_valid(byte_valid), .ack_slot(ack_slot)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   int bv_cnt = 0, start_cnt = 0, stop_cnt = 0, ack_cyc = 0, rise_cnt = 0;
   logic [7:0] bv_q[$];

   always @(negedge clk) begin
      if (n_rst) begin
         if (byte_valid) begin
            bv_cnt++;
            bv_q.push_back(rx_byte);
         end
         if (start_found) start_cnt++;
         if (stop_found)  stop_cnt++;
         if (ack_slot)    ack_cyc++;
         if (scl_rise)    rise_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_in = 1'b0; wait_clks(H);
      scl = 1'b0;    wait_clks(H);
   endtask

   task automatic i2c_rep_start();
      sda_in = 1'b1; wait_clks(H);
      scl = 1'b1;    wait_clks(H);
      sda_in = 1'b0; wait_clks(H);
      scl = 1'b0;    wait_clks(H);
   endtask

   task automatic i2c_stop();
      sda_in = 1'b0; wait_clks(H);
      scl = 1'b1;    wait_clks(H);
      sda_in = 1'b1; wait_clks(H);
   endtask

   // Entered and left with SCL low.
   task automatic send_bit(input logic b);
      sda_in = b;  wait_clks(H);
      scl = 1'b1;  wait_clks(2 * H);
      scl = 1'b0;  wait_clks(H);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      send_bit(1'b1);
   endtask

   typedef struct {
      logic [6:0] e0;
      logic [6:0] e1;
      logic [1:0] en;
      logic [7:0] addr;
      logic       exp_match;
      logic       exp_idx;
      logic       exp_rw;
   } vec_t;

   vec_t vecs[6];

   int b0, s0, p0, a0, r0;

   initial begin
      vecs[0] = '{e0: 7'h78, e1: 7'h00, en: 2'b01, addr: 8'hF1, exp_match: 1'b1, exp_idx: 1'b0, exp_rw: 1'b1};
      vecs[1] = '{e0: 7'h78, e1: 7'h3C, en: 2'b11, addr: 8'h78, exp_match: 1'b1, exp_idx: 1'b1, exp_rw: 1'b0};
      vecs[2] = '{e0: 7'h78, e1: 7'h3C, en: 2'b00, addr: 8'hF1, exp_match: 1'b0, exp_idx: 1'b0, exp_rw: 1'b1};
      vecs[3] = '{e0: 7'h78, e1: 7'h3C, en: 2'b10, addr: 8'hF0, exp_match: 1'b0, exp_idx: 1'b0, exp_rw: 1'b0};
      vecs[4] = '{e0: 7'h3C, e1: 7'h3C, en: 2'b11, addr: 8'h79, exp_match: 1'b1, exp_idx: 1'b0, exp_rw: 1'b1};
      vecs[5] = '{e0: 7'h00, e1: 7'h7F, en: 2'b10, addr: 8'hFF, exp_match: 1'b1, exp_idx: 1'b1, exp_rw: 1'b1};

      // Reset with idle bus
      wait_clks(4);
      check("reset_outputs_during", {start_found, stop_found, scl_rise, scl_fall, address_match,
            match_idx, rw_mode, rx_byte, byte_valid, ack_slot}, 32'h0);
      n_rst = 1'b1;
      wait_clks(10);
      check("reset_outputs_after", {start_found, stop_found, scl_rise, scl_fall, address_match,
            match_idx, rw_mode, rx_byte, byte_valid, ack_slot}, 32'h0);
      check("reset_no_pulses", start_cnt + stop_cnt + bv_cnt + rise_cnt, 0);

      // Address-phase table
      foreach (vecs[k]) begin
         slave_addrs = {vecs[k].e1, vecs[k].e0};
         addr_en     = vecs[k].en;
         b0 = bv_cnt; s0 = start_cnt; p0 = stop_cnt; a0 = ack_cyc; r0 = rise_cnt;
         i2c_start();
         send_byte(vecs[k].addr);
         check($sformatf("v%0d_start", k), start_cnt - s0, 1);
         check($sformatf("v%0d_bv_count", k), bv_cnt - b0, 1);
         check($sformatf("v%0d_rx_byte", k), rx_byte, vecs[k].addr);
         check($sformatf("v%0d_match", k), address_match, vecs[k].exp_match);
         check($sformatf("v%0d_idx", k), match_idx, vecs[k].exp_idx);
         check($sformatf("v%0d_rw", k), rw_mode, vecs[k].exp_rw);
         check($sformatf("v%0d_ack_cycles", k), ack_cyc - a0, vecs[k].exp_match ? 4 * H : 0);
         check($sformatf("v%0d_rises", k), rise_cnt - r0, 9);
         i2c_stop();
         wait_clks(6);
         check($sformatf("v%0d_stop", k), stop_cnt - p0, 1);
         check($sformatf("v%0d_cleared", k), {address_match, match_idx, rw_mode, ack_slot}, 0);
      end

      // Matched address then two data bytes
      slave_addrs = {7'h3C, 7'h78};
      addr_en = 2'b11;
      b0 = bv_cnt; a0 = ack_cyc;
      bv_q.delete();
      i2c_start();
      send_byte(8'h78);
      send_byte(8'hA5);
      send_byte(8'h5A);
      check("data_bv_count", bv_cnt - b0, 3);
      check("data_byte0", bv_q.size() > 1 ? bv_q[1] : 8'hXX, 8'hA5);
      check("data_byte1", bv_q.size() > 2 ? bv_q[2] : 8'hXX, 8'h5A);
      check("data_ack_cycles", ack_cyc - a0, 3 * 4 * H);
      check("data_match_held", {address_match, match_idx}, 2'b11);
      i2c_stop();
      wait_clks(6);
      check("data_stop_clears", address_match, 0);

      // Unmatched address goes to IGNORE; repeated START recovers
      b0 = bv_cnt; a0 = ack_cyc; s0 = start_cnt;
      i2c_start();
      send_byte(8'h10);
      send_byte(8'h55);
      check("ignore_bv_count", bv_cnt - b0, 1);
      check("ignore_rx_holds", rx_byte, 8'h10);
      check("ignore_no_ack", ack_cyc - a0, 0);
      check("ignore_no_match", address_match, 0);
      i2c_rep_start();
      send_byte(8'hF0);
      check("rstart_count", start_cnt - s0, 2);
      check("rstart_match", {address_match, match_idx, rw_mode}, 3'b100);
      check("rstart_rx", rx_byte, 8'hF0);
      i2c_stop();
      wait_clks(6);

      // STOP after 4 data bits discards the partial byte
      b0 = bv_cnt; p0 = stop_cnt;
      i2c_start();
      send_byte(8'hF0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      i2c_stop();
      wait_clks(6);
      check("abort_bv_count", bv_cnt - b0, 1);
      check("abort_stop", stop_cnt - p0, 1);
      check("abort_cleared", {address_match, rw_mode, ack_slot}, 0);
      check("abort_rx_holds", rx_byte, 8'hF0);
      // Clocking a byte without START must not produce data (FSM is IDLE)
      b0 = bv_cnt;
      scl = 1'b0; wait_clks(H);
      send_byte(8'hAA);
      scl = 1'b1; wait_clks(H);
      check("idle_no_bytes", bv_cnt - b0, 0);

      // Reset mid-byte
      i2c_start();
      send_byte(8'hF0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("prereset_match", address_match, 1);
      n_rst = 1'b0;
      #1;
      check("midreset_outputs", {start_found, stop_found, scl_rise, scl_fall, address_match,
            match_idx, rw_mode, rx_byte, byte_valid, ack_slot}, 32'h0);
      scl = 1'b1; sda_in = 1'b1;
      wait_clks(4);
      n_rst = 1'b1;
      b0 = bv_cnt; s0 = start_cnt; p0 = stop_cnt;
      wait_clks(20);
      check("postreset_quiet", (bv_cnt - b0) + (start_cnt - s0) + (stop_cnt - p0), 0);

`ifdef I2C_GLITCH_FILTER_EN
      // SDA glitches while SCL is high
      s0 = start_cnt;
      sda_in = 1'b0; wait_clks(2);
      sda_in = 1'b1; wait_clks(12);
      check("glitch_2clk_no_start", start_cnt - s0, 0);
      sda_in = 1'b0; wait_clks(4);
      sda_in = 1'b1; wait_clks(12);
      check("glitch_4clk_start", start_cnt - s0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
